aes_sub_bytes_pipe: RTL
=======================

// Module: aes_sub_bytes_pipe
// PURPOSE
//   Multi-lane AES SubBytes/InvSubBytes unit with a valid/ready elastic pipeline.
//   Replaces single-byte combinational S-box lookups in the datapath.
//   Substitutes LANES bytes per beat, forward or inverse per beat, with backpressure.
//   Sits between the AddRoundKey output and the ShiftRows stage of the round core.
// PARAMETERS
//   LANES        4    bytes substituted per beat (1..16); lane i = data[8*i+7:8*i]
//   PIPE_STAGES  2    register stages between input and output (1..4)
//   INV_EN       1    1: inverse S-box present, honours in_inv; 0: forward only
//   CNT_W        32   width of the completed-beat counter
// PORTS
//   clk        in   1          clock, all state on rising edge
//   rst        in   1          asynchronous reset, active-high
//   in_valid   in   1          input beat valid
//   in_ready   out  1          unit accepts beat this cycle
//   in_data    in   8*LANES    bytes to substitute
//   in_inv     in   1          1 = InvSubBytes for this beat (ignored if INV_EN=0)
//   out_valid  out  1          output beat valid
//   out_ready  in   1          downstream accepts beat
//   out_data   out  8*LANES    substituted bytes
//   out_inv    out  1          mode the beat was processed with
//   busy       out  1          any pipeline stage holds a valid beat
//   beat_cnt   out  CNT_W      beats delivered (out_valid & out_ready)
// BEHAVIOUR
//   - Reset (async, rst=1): all stage valids=0, stage data=0, beat_cnt=0;
//     out_valid=0, out_data=0, out_inv=0, busy=0. in_ready=1 one cycle after
//     rst deasserts (combinational from empty stages).
//   - Lookup: per lane, combinational on in_data before stage 0 register;
//     forward = FIPS-197 S-box, inverse = FIPS-197 inverse S-box. All lanes
//     use the same mode. INV_EN=0: forward only, stored inv bit forced to 0.
//   - Stage k (0..PIPE_STAGES-1) holds {valid, inv, data}. Last stage drives outputs.
//   - Advance rule: stage k loads from upstream when en_k = !valid_k | en_(k+1);
//     en_last = !valid_last | out_ready. in_ready = en_0 (combinational, ready
//     chain; no combinational path from in_valid to in_ready).
//   - Stage k loaded with valid_(k-1) (or in_valid for k=0); a stage whose
//     upstream is empty becomes invalid when it advances (bubble).
//   - Latency PIPE_STAGES cycles with out_ready=1; throughput 1 beat/cycle.
//   - Stall (out_ready=0, out_valid=1): out_data/out_inv/out_valid held stable;
//     stages fill until full; then in_ready=0. Input beat accepted only when
//     in_valid & in_ready; no beat dropped or duplicated.
//   - Data of invalid stages is don't-care but must not be observed; out_data
//     registers update only on load with valid=1 (hold otherwise).
//   - Mixed modes back-to-back: each beat keeps its own inv bit through the pipe.
//   - beat_cnt += 1 on out_valid & out_ready; wraps 2^CNT_W-1 -> 0 silently.
//   - busy = OR of stage valids.
//   - rst asserted mid-operation: all in-flight beats discarded immediately;
//     no output beat after rst release until new inputs traverse the pipe.
// TESTING
//   1. LANES=4, fwd, in_data=0xFF53_0100 -> after 2 cycles out_data=0x16ED_7C63, out_inv=0.
//   2. inv, in_data=0x16ED_7C63 -> out_data=0xFF53_0100, out_inv=1; round-trip all 256
//      bytes (lane-rotated) returns input.
//   3. Stream 8 beats alternating fwd/inv, out_ready=1 -> 8 outputs, 1/cycle, modes
//      matched, beat_cnt=8.
//   4. out_ready=0 for 5 cycles while in_valid=1 -> exactly PIPE_STAGES beats accepted,
//      in_ready=0 after, out_data stable; release -> remaining beats in order, none lost.
//   5. rst pulse with 2 beats in flight -> out_valid=0, busy=0, beat_cnt=0 same cycle;
//      no stale beat after release.
//   6. INV_EN=0, in_inv=1, in_data=0x00000053 -> out_data=0x636363ED, out_inv=0;
//      CNT_W=4: 17 beats -> beat_cnt=1.

Source files
------------

// File: rtl/aes_sub_bytes_pipe.sv
// ---------------------------------------------------------------------------
// aes_sub_bytes_pipe
//
// Multi-lane AES SubBytes / InvSubBytes unit behind a valid/ready elastic
// pipeline. It sits between AddRoundKey and ShiftRows in the round core.
// Each beat substitutes LANES bytes. Lane i is data[8*i+7:8*i].
// Each beat selects forward or inverse substitution for itself. The selected
// mode travels with the beat through the pipe.
//
// Substitution is a combinational table lookup ahead of stage 0. After that
// come PIPE_STAGES register stages, and each stage holds {valid, inv, data}.
// A stage advances when it is empty or when the stage after it advances.
// in_ready is therefore a pure ready chain that depends only on stage state
// and out_ready. It never depends on in_valid.
//
// Parameters
//   LANES        bytes per beat (1..16)
//   PIPE_STAGES  register stages, equal to the latency (1..4)
//   INV_EN       1: in_inv honoured; 0: forward only, inv bit forced to 0
//   CNT_W        width of the delivered-beat counter
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-high
//   in_valid   in   input beat valid
//   in_ready   out  unit accepts a beat this cycle
//   in_data    in   bytes to substitute (8*LANES)
//   in_inv     in   1 = InvSubBytes for this beat
//   out_valid  out  output beat valid
//   out_ready  in   downstream accepts the beat
//   out_data   out  substituted bytes (8*LANES)
//   out_inv    out  mode the beat was processed with
//   busy       out  any stage holds a valid beat
//   beat_cnt   out  beats delivered, wraps silently (CNT_W)
// ---------------------------------------------------------------------------
module aes_sub_bytes_pipe #(
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 2,
  parameter bit INV_EN      = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  input  logic                 in_inv,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic                 out_inv,
  output logic                 busy,
  output logic [CNT_W-1:0]     beat_cnt
);

  localparam int DW = 8 * LANES;

  // FIPS-197 forward S-box, indexed by the input byte.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // FIPS-197 inverse S-box, indexed by the input byte.
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Pipeline state.
  logic [PIPE_STAGES-1:0] r_valid;
  logic [PIPE_STAGES-1:0] r_inv;
  logic [DW-1:0]          r_data [PIPE_STAGES];
  logic [CNT_W-1:0]       r_beat_cnt;

  // Combinational signals.
  logic                   w_inv_sel;
  logic [DW-1:0]          w_sub_data;
  logic [PIPE_STAGES-1:0] w_en;
  logic [PIPE_STAGES-1:0] w_up_valid;
  logic [PIPE_STAGES-1:0] w_up_inv;
  logic [DW-1:0]          w_up_data [PIPE_STAGES];
  logic                   w_out_fire;

  // Byte substitution ahead of stage 0. All lanes share one mode. When
  // INV_EN is 0 the inverse branch is constant-false and drops out.
  always_comb begin : lookup
    // NOTE: every output of a combinational block gets a value on every
    // path, defaults first, so that no latch is inferred.
    w_inv_sel  = INV_EN & in_inv;
    w_sub_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_inv_sel) w_sub_data[8*i +: 8] = INV_SBOX[in_data[8*i +: 8]];
      else           w_sub_data[8*i +: 8] = SBOX[in_data[8*i +: 8]];
    end
  end

  // Ready chain, walked from the output back towards the input.
  // A stage may load when it is empty or when its own content moves on.
  always_comb begin : ready_chain
    logic w_down;
    w_en   = '0;
    w_down = out_ready;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      w_down  = !r_valid[k] | w_down;
      w_en[k] = w_down;
    end
  end

  // Upstream source for each stage: the lookup for stage 0 and the previous
  // stage for every later stage.
  always_comb begin : upstream
    w_up_valid    = '0;
    w_up_inv      = '0;
    w_up_valid[0] = in_valid;
    w_up_inv[0]   = w_inv_sel;
    w_up_data[0]  = w_sub_data;
    for (int k = 1; k < PIPE_STAGES; k++) begin
      w_up_valid[k] = r_valid[k-1];
      w_up_inv[k]   = r_inv[k-1];
      w_up_data[k]  = r_data[k-1];
    end
  end

  // Stage registers. An advancing stage always takes the upstream valid bit,
  // so an empty upstream leaves a bubble. The payload is written only when
  // a real beat arrives. An invalid stage therefore never disturbs out_data.
  always_ff @(posedge clk or posedge rst) begin : stages
    if (rst) begin
      // NOTE: the data registers are reset as well as the valids, so that
      // out_data reads as zero after reset and never shows stale bytes.
      r_valid <= '0;
      r_inv   <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) r_data[k] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every stage
      // reads its neighbour's value from before the clock edge.
      for (int k = 0; k < PIPE_STAGES; k++) begin
        if (w_en[k]) begin
          r_valid[k] <= w_up_valid[k];
          if (w_up_valid[k]) begin
            r_inv[k]  <= w_up_inv[k];
            r_data[k] <= w_up_data[k];
          end
        end
      end
    end
  end

  assign w_out_fire = r_valid[PIPE_STAGES-1] & out_ready;

  // Delivered-beat counter. It wraps silently at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin : counter
    if (rst)             r_beat_cnt <= '0;
    else if (w_out_fire) r_beat_cnt <= r_beat_cnt + CNT_W'(1);
  end

  assign in_ready  = w_en[0];
  assign out_valid = r_valid[PIPE_STAGES-1];
  assign out_inv   = r_inv[PIPE_STAGES-1];
  assign out_data  = r_data[PIPE_STAGES-1];
  assign busy      = |r_valid;
  assign beat_cnt  = r_beat_cnt;

endmodule
